// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the multi-cycle restoring divider.
// Holds the FSM state encoding and the iteration counter width.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: (n+1)-bit trial subtract plus restore mux.
module seq_divider_div_step #(
    parameter int unsigned n = 32
) (
    input  logic [n-1:0] rem,
    input  logic         dvd_msb,
    input  logic [n-1:0] dvs,
    output logic [n-1:0] rem_next,
    output logic         q_bit
);

    logic [n:0] shifted;
    logic [n:0] diff;

    assign shifted = {rem, dvd_msb};
    assign diff    = shifted - {1'b0, dvs};

    // A set top bit in the shifted remainder already exceeds any n-bit divisor;
    // otherwise the difference lies in (-2^n, 2^n) and its top bit is the sign.
    assign q_bit    = shifted[n] | ~diff[n];
    assign rem_next = q_bit ? diff[n-1:0] : shifted[n-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient on LO and remainder on HI, with a start/busy/done handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sign,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder
);

    localparam int unsigned CW = cnt_width(n);
    localparam logic [CW-1:0] LastIter = CW'(n - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [n-1:0]  rem_q;
    logic [n-1:0]  dvd_q;
    logic [n-1:0]  dvs_q;
    logic [n-1:0]  a_orig_q;
    logic          sign_q;
    logic          a_neg_q;
    logic          b_neg_q;

    logic [n-1:0]  a_abs;
    logic [n-1:0]  b_abs;
    logic [n-1:0]  step_rem;
    logic          step_q;
    logic [n-1:0]  q_fixed;
    logic [n-1:0]  r_fixed;
    logic          dz;

    assign a_abs = (sign && A[n-1]) ? -A : A;
    assign b_abs = (sign && B[n-1]) ? -B : B;

    seq_divider_div_step #(
        .n(n)
    ) u_div_step (
        .rem     (rem_q),
        .dvd_msb (dvd_q[n-1]),
        .dvs     (dvs_q),
        .rem_next(step_rem),
        .q_bit   (step_q)
    );

    // Divide by zero bypasses sign correction: all-ones quotient, original A back.
    assign dz      = (dvs_q == '0);
    assign q_fixed = dz ? '1 :
                     (sign_q && (a_neg_q ^ b_neg_q)) ? -dvd_q : dvd_q;
    assign r_fixed = dz ? a_orig_q :
                     (sign_q && a_neg_q) ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LastIter) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            a_orig_q    <= '0;
            sign_q      <= 1'b0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sign_q   <= sign;
                        a_neg_q  <= A[n-1];
                        b_neg_q  <= B[n-1];
                        a_orig_q <= A;
                        dvd_q    <= a_abs;
                        dvs_q    <= b_abs;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                S_RUN: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[n-2:0], step_q};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    quotient    <= q_fixed;
                    remainder   <= r_fixed;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring integer divider for the MIPS datapath, executing DIV/DIVU. It takes an n-bit dividend and divisor, iterates one quotient bit per clock, and returns quotient (LO) and remainder (HI) with a start/busy/done handshake. It sits beside the single-cycle arithmetic unit in the execute stage; the pipeline stalls on `busy`.

## Interface
- `n`, 32, operand/result width; any value ≥ 4 is legal.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when idle.
- `sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start`.
- `A`  in  n  dividend; sampled with `start`.
- `B`  in  n  divisor; sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  single-cycle completion pulse.
- `div_by_zero`  out  1  registered with results; 1 if the sampled `B` was 0.
- `quotient`  out  n  registered result (LO).
- `remainder`  out  n  registered result (HI).

## Operation
- States: IDLE, RUN, FIX. Reset forces IDLE. All outputs reset to 0.
- IDLE with `start`=1: latch `sign`, the raw operand signs, and the magnitudes |A| and |B| (absolute values only when `sign`=1). Clear the partial remainder and iteration counter. Go to RUN.
- RUN: each cycle, shift {rem, dividend} left by 1 and trial-subtract the divisor from the (n+1)-bit partial remainder. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0. After exactly n iterations (counter n-1 → wrap), go to FIX.
- FIX: apply the signs and register the outputs. Go to IDLE.
  - Quotient is negated if the operand signs differ (signed mode only).
  - Remainder is negated if the dividend was negative (signed mode only).
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero runs the full latency. It forces quotient = all ones and remainder = the original A, and sets `div_by_zero`=1.
- Signed overflow (A = −2^(n−1), B = −1) returns quotient = 0x80000000 and remainder = 0 for n = 32. This is natural wrap, with no flag.
- `start` while busy is ignored; operands are not re-sampled.
- `quotient`, `remainder` and `div_by_zero` hold their values until the next completion. They are not cleared by a new `start`.

## Timing
- Accept edge E0 (IDLE, `start`=1). `busy`=1 from E0 through E(n+1).
- RUN occupies edges E1…En.
- FIX completes at E(n+1). Results become valid, `done`=1, and `busy`=0 after E(n+1). The `start`→`done` latency is n+1 cycles, which is 33 for n=32.
- `done` stays high for exactly one cycle. The state is IDLE during that cycle, so a `start` asserted in the same cycle is accepted (back-to-back, throughput one op per n+1 cycles).
- Reset mid-operation, at any edge with `rst`=1:
  - Go to IDLE and clear all outputs and the counter.
  - No `done` is produced for the aborted operation.
  - Reset has priority over `start`.

## Structure
- Shared package holds:
  - State encoding constants `S_IDLE`, `S_RUN`, `S_FIX`.
  - The iteration counter width, `$clog2(n)`.
- One sub-module is natural: `div_step`. It is combinational, (n+1)-bit trial subtract plus restore mux, and outputs the next partial remainder and the quotient bit. Negation and abs helpers stay inline.

## Test plan
- Unsigned: `sign`=0, A=100, B=7 → after 33 cycles `done`, quotient=14, remainder=2, `div_by_zero`=0.
- Signed mixed: `sign`=1, A=−7 (0xFFFFFFF9), B=2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1).
- Zero / overflow:
  - A=0x12345678, B=0 → quotient=0xFFFFFFFF, remainder=0x12345678, `div_by_zero`=1.
  - Signed A=0x80000000, B=0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Handshake:
  - Pulse `start` again at E5 with different operands → ignored, and the first result is returned.
  - Assert `start` during the `done` cycle → second result arrives exactly 33 cycles later.
- Reset mid-op: `rst` at E10 → `busy`=0, outputs 0, no `done`. A following `start` with A=9, B=3 gives quotient=3, remainder=0.
- Unsigned max: `sign`=0, A=0xFFFFFFFF, B=0x80000000 → quotient=1, remainder=0x7FFFFFFF.
